// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding and counter width for the RAM_IF SRAM controller.
package ram_pkg;
    typedef enum logic [2:0] {IDLE, RD, WR, RF, HOLD, RELEASE} ram_state_t;
    localparam int WAIT_CNT_BITS = 4;
endpackage

// File: rtl/ram_sram_controller_if.sv
// ram_sram_controller_if: RAM_IF host bus; the host holds a strobe low until ACK_n pulses.
interface ram_sram_controller_if #(parameter int ADDR_BIT_WIDTH = 24);
    logic [ADDR_BIT_WIDTH-1:0] ADDR;
    logic                      OE_n;
    logic                      WE_n;
    logic                      RFSH_n;
    logic [7:0]                DIN;
    logic [15:0]               DOUT;
    logic                      ACK_n;
    modport master (output ADDR, OE_n, WE_n, RFSH_n, DIN, input DOUT, ACK_n);
    modport slave (input ADDR, OE_n, WE_n, RFSH_n, DIN, output DOUT, ACK_n);
endinterface

// File: rtl/ram_read_buffer.sv
// ram_read_buffer: one-word read buffer (valid + word address + data), built only with RAM_SRAM_CTRL_READ_BUFFER_EN.
`ifdef RAM_SRAM_CTRL_READ_BUFFER_EN
module ram_read_buffer #(parameter int AW = 23) (
    input  logic          CLK,
    input  logic          RESET_n,
    input  logic [AW-1:0] lookup_addr,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [15:0]   fill_data,
    input  logic          upd,
    input  logic [AW-1:0] upd_addr,
    input  logic          upd_hi,
    input  logic [7:0]    upd_data,
    output logic          hit,
    output logic [15:0]   data
);
    logic          valid;
    logic [AW-1:0] tag;
    assign hit = valid && tag == lookup_addr;
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            data  <= fill_data;
        end else if (upd && valid && tag == upd_addr) begin
            if (upd_hi) data[15:8] <= upd_data;
            else data[7:0] <= upd_data;
        end
    end
endmodule
`endif

// File: rtl/ram_sram_controller.sv
// ram_sram_controller: RAM_IF device terminator driving a 16-bit async SRAM.
// Optional read buffer enabled by `RAM_SRAM_CTRL_READ_BUFFER_EN.
module ram_sram_controller
    import ram_pkg::*;
#(
    parameter int ADDR_BIT_WIDTH = 24,
    parameter int WAIT_CYCLES    = 2
) (
    input  logic                      CLK,
    input  logic                      RESET_n,
    ram_sram_controller_if.slave      host,
    output logic [ADDR_BIT_WIDTH-2:0] SRAM_A,
    input  logic [15:0]               SRAM_DQ_I,
    output logic [15:0]               SRAM_DQ_O,
    output logic                      SRAM_DQ_OE,
    output logic                      SRAM_CE_n,
    output logic                      SRAM_OE_n,
    output logic                      SRAM_WE_n,
    output logic                      SRAM_LB_n,
    output logic                      SRAM_UB_n
);
    localparam logic [WAIT_CNT_BITS-1:0] W = WAIT_CYCLES[WAIT_CNT_BITS-1:0];
    ram_state_t                state, nxt;
    logic [WAIT_CNT_BITS-1:0]  cnt;
    logic [ADDR_BIT_WIDTH-1:0] addr_q;
    logic [7:0]                din_q;
    logic                      is_wr, hit_q, req, hit, hit_rd, cap, access, lanes_on;
    logic [15:0]               dout_q, buf_data;
    assign req       = ~&{host.OE_n, host.WE_n, host.RFSH_n};
    assign hit_rd    = state == IDLE && host.WE_n && !host.OE_n && hit;
    assign cap       = state == RD && !hit_q && cnt == W;
    assign SRAM_A    = addr_q[ADDR_BIT_WIDTH-1:1];
    assign SRAM_DQ_O = {din_q, din_q};
    assign host.DOUT = dout_q;
`ifdef RAM_SRAM_CTRL_READ_BUFFER_EN
    ram_read_buffer #(.AW(ADDR_BIT_WIDTH-1)) u_buf (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .lookup_addr(host.ADDR[ADDR_BIT_WIDTH-1:1]),
        .fill       (cap),
        .fill_addr  (addr_q[ADDR_BIT_WIDTH-1:1]),
        .fill_data  (SRAM_DQ_I),
        .upd        (state == HOLD && is_wr),
        .upd_addr   (addr_q[ADDR_BIT_WIDTH-1:1]),
        .upd_hi     (addr_q[0]),
        .upd_data   (din_q),
        .hit        (hit),
        .data       (buf_data)
    );
`else
    assign hit      = 1'b0;
    assign buf_data = '0;
`endif
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            din_q  <= '0;
            is_wr  <= 1'b0;
            hit_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            state <= nxt;
            cnt   <= state == IDLE ? '0 : cnt + 1'b1;
            if (state == IDLE) hit_q <= hit_rd;
            if (state == IDLE && req) begin
                addr_q <= host.ADDR;
                din_q  <= host.DIN;
                is_wr  <= !host.WE_n;
            end
            if (cap) dout_q <= SRAM_DQ_I;
            else if (hit_rd) dout_q <= buf_data;
        end
    end
    // Strobes decode straight from state so an async reset releases them immediately.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !host.WE_n ? WR : !host.OE_n ? RD : !host.RFSH_n ? RF : IDLE;
            RD:      nxt = hit_q ? RELEASE : cnt == W ? HOLD : RD;
            WR:      nxt = cnt == W ? HOLD : WR;
            RF:      nxt = cnt[0] ? RELEASE : RF;
            HOLD:    nxt = RELEASE;
            RELEASE: nxt = req ? RELEASE : IDLE;
            default: nxt = IDLE;
        endcase
        access     = (state == RD && !hit_q) || state == WR;
        lanes_on   = access || state == HOLD;
        SRAM_CE_n  = !access;
        SRAM_OE_n  = !(state == RD && !hit_q);
        SRAM_WE_n  = state != WR;
        SRAM_LB_n  = !(lanes_on && (!is_wr || !addr_q[0]));
        SRAM_UB_n  = !(lanes_on && (!is_wr || addr_q[0]));
        SRAM_DQ_OE = is_wr && (state == WR || state == HOLD);
        host.ACK_n = !(state == HOLD || (state == RF && cnt[0]) || (state == RD && hit_q));
    end
endmodule

// File: tb/tb_ram_sram_controller.sv
// tb_ram_sram_controller: directed self-checking bench for ram_sram_controller with a byte-lane SRAM model.
module tb_ram_sram_controller;
`ifdef RAM_SRAM_CTRL_READ_BUFFER_EN
    localparam int HIT_ACK = 1, HIT_CE = 0;
`else
    localparam int HIT_ACK = 4, HIT_CE = 3;
`endif
    logic CLK = 1'b0, RESET_n = 1'b0, mem_init = 1'b1;
    always #5 CLK = ~CLK;
    ram_sram_controller_if #(.ADDR_BIT_WIDTH(24)) bus ();
    ram_sram_controller_if #(.ADDR_BIT_WIDTH(24)) bus0 ();
    ram_sram_controller_if #(.ADDR_BIT_WIDTH(24)) bus15 ();
    logic [22:0] sram_a, a0, a15;
    logic [15:0] sram_dq_i, sram_dq_o, dqo0, dqo15;
    logic sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
    logic oe0, ce0, soe0, we0, lb0, ub0, oe15, ce15, soe15, we15, lb15, ub15;
    logic [15:0] mem [0:1023];
    ram_sram_controller #(.ADDR_BIT_WIDTH(24), .WAIT_CYCLES(2)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .host(bus), .SRAM_A(sram_a), .SRAM_DQ_I(sram_dq_i),
        .SRAM_DQ_O(sram_dq_o), .SRAM_DQ_OE(sram_dq_oe), .SRAM_CE_n(sram_ce_n), .SRAM_OE_n(sram_oe_n),
        .SRAM_WE_n(sram_we_n), .SRAM_LB_n(sram_lb_n), .SRAM_UB_n(sram_ub_n));
    ram_sram_controller #(.ADDR_BIT_WIDTH(24), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .RESET_n(RESET_n), .host(bus0), .SRAM_A(a0), .SRAM_DQ_I(16'h0F0F),
        .SRAM_DQ_O(dqo0), .SRAM_DQ_OE(oe0), .SRAM_CE_n(ce0), .SRAM_OE_n(soe0),
        .SRAM_WE_n(we0), .SRAM_LB_n(lb0), .SRAM_UB_n(ub0));
    ram_sram_controller #(.ADDR_BIT_WIDTH(24), .WAIT_CYCLES(15)) dut15 (
        .CLK(CLK), .RESET_n(RESET_n), .host(bus15), .SRAM_A(a15), .SRAM_DQ_I(16'hF0F0),
        .SRAM_DQ_O(dqo15), .SRAM_DQ_OE(oe15), .SRAM_CE_n(ce15), .SRAM_OE_n(soe15),
        .SRAM_WE_n(we15), .SRAM_LB_n(lb15), .SRAM_UB_n(ub15));
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a[9:0]] : 16'hDEAD;
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
            mem[10'h080] <= 16'h1234;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_a[9:0]][7:0] <= sram_dq_o[7:0];
            if (!sram_ub_n) mem[sram_a[9:0]][15:8] <= sram_dq_o[15:8];
        end
    end
    int n_chk = 0, n_fail = 0;
    int ack_cyc, ack_cnt, oe_lo, we_lo, ce_lo, lb_lo, ub_lo, dqoe_cyc;
    logic [22:0] a_seen;
    logic [15:0] dqo_seen;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic release_bus();
        bus.OE_n = 1'b1;
        bus.WE_n = 1'b1;
        bus.RFSH_n = 1'b1;
    endtask
    // Cycle 1 is the first cycle after the accepting edge; hold>0 keeps the strobe low that many cycles.
    task automatic access(input logic we, input logic oe, input logic rf, input logic [23:0] addr,
                          input logic [7:0] din, input int hold);
        int post;
        bit rel;
        {ack_cyc, ack_cnt, oe_lo, we_lo, ce_lo, lb_lo, ub_lo, dqoe_cyc, post} = '0;
        rel = 1'b0;
        a_seen = '0;
        dqo_seen = '0;
        @(negedge CLK);
        bus.ADDR = addr;
        bus.DIN = din;
        bus.WE_n = !we;
        bus.OE_n = !oe;
        bus.RFSH_n = !rf;
        for (int c = 1; c <= 60 && post < 5; c++) begin
            @(negedge CLK);
            if (!bus.ACK_n) begin
                ack_cnt++;
                if (ack_cyc == 0) ack_cyc = c;
            end
            if (!sram_oe_n) begin oe_lo++; a_seen = sram_a; end
            if (!sram_we_n) begin we_lo++; dqo_seen = sram_dq_o; end
            if (!sram_ce_n) ce_lo++;
            if (!sram_lb_n) lb_lo++;
            if (!sram_ub_n) ub_lo++;
            if (sram_dq_oe) dqoe_cyc++;
            if (rel) post++;
            else if (hold > 0 ? c >= hold : ack_cnt > 0) begin
                release_bus();
                rel = 1'b1;
            end
        end
        release_bus();
    endtask
    initial begin
        int ack;
        release_bus();
        bus.ADDR = '0;
        bus.DIN = '0;
        {bus0.OE_n, bus0.WE_n, bus0.RFSH_n, bus15.OE_n, bus15.WE_n, bus15.RFSH_n} = '1;
        bus0.ADDR = '0;
        bus0.DIN = '0;
        bus15.ADDR = '0;
        bus15.DIN = '0;
        #1;
        check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 5'b11111);
        check("rst_dq_oe", sram_dq_oe, 1'b0);
        check("rst_sram_a", sram_a, 23'h0);
        check("rst_dq_o", sram_dq_o, 16'h0);
        check("rst_dout", bus.DOUT, 16'h0);
        check("rst_ack", bus.ACK_n, 1'b1);
        repeat (3) @(negedge CLK);
        RESET_n = 1'b1;
        mem_init = 1'b0;
        // 1: read word 0x80
        access(1'b0, 1'b1, 1'b0, 24'h000100, 8'h00, 0);
        check("rd_ack_cyc", ack_cyc, 4);
        check("rd_ack_cnt", ack_cnt, 1);
        check("rd_oe_lo", oe_lo, 3);
        check("rd_sram_a", a_seen, 23'h80);
        check("rd_lanes", {lb_lo, ub_lo}, {32'd4, 32'd4});
        check("rd_dout", bus.DOUT, 16'h1234);
        // 2: upper-byte write then read back
        access(1'b1, 1'b0, 1'b0, 24'h000101, 8'hAB, 0);
        check("wr_ack_cyc", ack_cyc, 4);
        check("wr_we_lo", we_lo, 3);
        check("wr_lanes", {lb_lo, ub_lo}, {32'd0, 32'd4});
        check("wr_dq_o", dqo_seen, 16'hABAB);
        check("wr_dq_oe", dqoe_cyc, 4);
        check("wr_dout_kept", bus.DOUT, 16'h1234);
        access(1'b0, 1'b1, 1'b0, 24'h000100, 8'h00, 0);
        check("rb_dout", bus.DOUT, 16'hAB34);
        // 3: strobe held 20 cycles
        access(1'b0, 1'b1, 1'b0, 24'h000200, 8'h00, 20);
        check("hold_ack_cnt", ack_cnt, 1);
        check("hold_oe_lo", oe_lo, 3);
        check("hold_ack_cyc", ack_cyc, 4);
        check("hold_dout", bus.DOUT, 16'h0000);
        // 4: write wins over read; refresh alone
        access(1'b1, 1'b1, 1'b0, 24'h000102, 8'h5A, 0);
        check("pri_we_lo", we_lo, 3);
        check("pri_oe_lo", oe_lo, 0);
        check("pri_ack_cyc", ack_cyc, 4);
        check("pri_lanes", {lb_lo, ub_lo}, {32'd4, 32'd0});
        access(1'b0, 1'b0, 1'b1, 24'h000000, 8'h00, 0);
        check("rf_ack_cyc", ack_cyc, 2);
        check("rf_ce_lo", ce_lo, 0);
        check("rf_ack_cnt", ack_cnt, 1);
        // 5: async reset in write cycle 2
        @(negedge CLK);
        bus.ADDR = 24'h000104;
        bus.DIN = 8'h11;
        bus.WE_n = 1'b0;
        repeat (2) @(negedge CLK);
        check("mid_we_active", sram_we_n, 1'b0);
        RESET_n = 1'b0;
        #1;
        check("mid_rst_strobes", {sram_we_n, sram_ce_n}, 2'b11);
        check("mid_rst_dq_oe", sram_dq_oe, 1'b0);
        check("mid_rst_ack", bus.ACK_n, 1'b1);
        release_bus();
        @(negedge CLK);
        RESET_n = 1'b1;
        access(1'b0, 1'b1, 1'b0, 24'h000102, 8'h00, 0);
        check("post_rst_ack", ack_cyc, 4);
        check("post_rst_dout", bus.DOUT, 16'h005A);
        // 6: repeated read (buffer hit when enabled) and wait-state sweep
        access(1'b0, 1'b1, 1'b0, 24'h000102, 8'h00, 0);
        check("rep_ack_cyc", ack_cyc, HIT_ACK);
        check("rep_ce_lo", ce_lo, HIT_CE);
        check("rep_dout", bus.DOUT, 16'h005A);
        @(negedge CLK);
        bus0.OE_n = 1'b0;
        ack = 0;
        for (int c = 1; c <= 40 && ack == 0; c++) begin
            @(negedge CLK);
            if (!bus0.ACK_n) ack = c;
        end
        bus0.OE_n = 1'b1;
        check("w0_ack_cyc", ack, 2);
        check("w0_dout", bus0.DOUT, 16'h0F0F);
        @(negedge CLK);
        bus15.OE_n = 1'b0;
        ack = 0;
        for (int c = 1; c <= 40 && ack == 0; c++) begin
            @(negedge CLK);
            if (!bus15.ACK_n) ack = c;
        end
        bus15.OE_n = 1'b1;
        check("w15_ack_cyc", ack, 17);
        check("w15_dout", bus15.DOUT, 16'hF0F0);
        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
